act_quantizer: RTL

ACT_QUANTIZER -- requirements
Module: act_quantizer

---
 rtl/act_quant_pkg.sv | 24 ++
 rtl/sat_counter.sv | 26 ++
 rtl/act_quantizer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/act_quant_pkg.sv
// Shared constants and helpers for the activation quantizer.
// Holds default widths, the saturation counter width and the clip limits
// derived from the LUT address width.
package act_quant_pkg;

    localparam int ACC_WIDTH_DEF = 16;
    localparam int MEM_WIDTH_DEF = 5;
    localparam int SHIFT_DEF     = 4;
    localparam int SAT_CNT_WIDTH = 16;

    // Largest signed value that still fits a mem_w-bit offset-binary address
    function automatic int clip_max(input int mem_w);
        return (1 << (mem_w - 1)) - 1;
    endfunction

    // Most negative signed value that still fits a mem_w-bit offset-binary address
    function automatic int clip_min(input int mem_w);
        return -(1 << (mem_w - 1));
    endfunction

    localparam int CLIP_MAX_DEF = (1 << (MEM_WIDTH_DEF - 1)) - 1;
    localparam int CLIP_MIN_DEF = -(1 << (MEM_WIDTH_DEF - 1));

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones,
// and clr wins over a simultaneous inc.
module sat_counter
    import act_quant_pkg::*;
#(
    parameter int WIDTH = SAT_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // Count register: reset/clear to zero, otherwise increment until full
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/act_quantizer.sv
// Activation quantizer: scales a signed MAC accumulator down by SHIFT
// fractional bits, clips it to the sigmoid LUT range and presents an
// offset-binary LUT address. Three-stage elastic pipeline with a
// consumer-side stall; while stalled the LUT keeps re-reading the held
// address so its registered output stays stable.
// Optional macro ACT_QUANT_ROUND_EN: round half up instead of truncating.
module act_quantizer
    import act_quant_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int MEM_WIDTH = MEM_WIDTH_DEF,
    parameter int SHIFT     = SHIFT_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [ACC_WIDTH-1:0] acc_in,
    input  logic                        acc_valid,
    output logic                        acc_ready,
    output logic [MEM_WIDTH-1:0]        addr_out,
    output logic                        lut_valid,
    input  logic                        out_ready,
    input  logic                        sat_clr,
    output logic [SAT_CNT_WIDTH-1:0]    sat_count
);

    localparam logic signed [ACC_WIDTH-1:0] LIM_HI   = ACC_WIDTH'(clip_max(MEM_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] LIM_LO   = ACC_WIDTH'(clip_min(MEM_WIDTH));
    localparam logic [MEM_WIDTH-1:0]        MSB_MASK = MEM_WIDTH'(1) << (MEM_WIDTH - 1);

    logic signed [ACC_WIDTH-1:0] r_s1_val;
    logic                        r_s1_valid;
    logic [MEM_WIDTH-1:0]        r_s2_addr;
    logic                        r_s2_valid;
    logic [MEM_WIDTH-1:0]        r_s3_addr;
    logic                        r_lut_valid;

    logic signed [ACC_WIDTH-1:0] w_s1_next;
    logic [MEM_WIDTH-1:0]        w_s2_next_addr;
    logic                        w_clipped;
    logic                        w_stall;
    logic                        w_en1;
    logic                        w_en2;
    logic                        w_en3;
    logic                        w_sat_inc;

`ifdef ACT_QUANT_ROUND_EN
    // One extra bit so adding the half-LSB bias to the largest positive
    // accumulator cannot wrap negative.
    localparam logic signed [ACC_WIDTH:0] RND_BIAS =
        (SHIFT > 0) ? ((ACC_WIDTH+1)'(1) << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : '0;

    logic signed [ACC_WIDTH:0] w_rnd_sum;

    assign w_rnd_sum = $signed({acc_in[ACC_WIDTH-1], acc_in}) + RND_BIAS;
    assign w_s1_next = ACC_WIDTH'(w_rnd_sum >>> SHIFT);
`else
    assign w_s1_next = acc_in >>> SHIFT;
`endif

    // Handshake: a held LUT result blocks stage 3; empty stages still fill
    always_comb begin
        w_stall   = 1'b0;
        w_en3     = 1'b1;
        w_en2     = 1'b1;
        w_en1     = 1'b1;
        w_stall   = r_lut_valid && !out_ready;
        w_en3     = !w_stall;
        w_en2     = !r_s2_valid || w_en3;
        w_en1     = !r_s1_valid || w_en2;
        acc_ready = w_en1;
    end

    // Clip stage-1 value to the LUT range and convert to offset binary
    always_comb begin
        w_s2_next_addr = '0;
        w_clipped      = 1'b0;
        if (r_s1_val > LIM_HI) begin
            w_s2_next_addr = {MEM_WIDTH{1'b1}};
            w_clipped      = 1'b1;
        end else if (r_s1_val < LIM_LO) begin
            w_s2_next_addr = '0;
            w_clipped      = 1'b1;
        end else begin
            w_s2_next_addr = r_s1_val[MEM_WIDTH-1:0] ^ MSB_MASK;
            w_clipped      = 1'b0;
        end
    end

    // LUT address: hold the presented address while the consumer stalls
    always_comb begin
        addr_out  = r_s2_addr;
        lut_valid = r_lut_valid;
        if (w_stall) begin
            addr_out = r_s3_addr;
        end else begin
            addr_out = r_s2_addr;
        end
    end

    assign w_sat_inc = w_en2 && r_s1_valid && w_clipped;

    // Stage 1: capture the scaled accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_val   <= '0;
        end else if (w_en1) begin
            r_s1_valid <= acc_valid;
            if (acc_valid) begin
                r_s1_val <= w_s1_next;
            end
        end
    end

    // Stage 2: capture the clipped offset-binary address
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_addr  <= '0;
        end else if (w_en2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_addr <= w_s2_next_addr;
            end
        end
    end

    // Stage 3: track the address the LUT has just registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lut_valid <= 1'b0;
            r_s3_addr   <= '0;
        end else if (w_en3) begin
            r_lut_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_s3_addr <= r_s2_addr;
            end
        end
    end

    sat_counter #(
        .WIDTH (SAT_CNT_WIDTH)
    ) u_sat_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_sat_inc),
        .clr   (sat_clr),
        .count (sat_count)
    );

endmodule
